// File: rtl/agc_timing_pkg.sv
// Shared timing definitions for the AGC time-pulse decoder: FSM state
// encoding, fail codes, pulse count and the Johnson / pulse decode helpers.
package agc_timing_pkg;

    typedef enum logic [1:0] {
        TPDEC_UNSYNC = 2'd0,
        TPDEC_SYNC   = 2'd1,
        TPDEC_FAIL   = 2'd2
    } tpdec_state_e;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_WDOG  = 2'b01;
    localparam logic [1:0] FC_SYNC  = 2'b10;
    localparam logic [1:0] FC_PHASE = 2'b11;

    localparam int TP_COUNT = 12;

    // Legal successor of a 5-stage Johnson counter value.
    function automatic logic [4:0] johnson_next(input logic [4:0] p);
        return {p[3:0], ~p[4]};
    endfunction

    // Active-low one-hot pulse lines for pulse number n (1..12); 0 gives all ones.
    function automatic logic [TP_COUNT-1:0] tp_decode(input logic [3:0] n);
        logic [TP_COUNT-1:0] one_hot;
        one_hot = '0;
        for (int i = 0; i < TP_COUNT; i++) begin
            if (n == 4'(i + 1)) one_hot[i] = 1'b1;
        end
        return ~one_hot;
    endfunction

endpackage

// File: rtl/agc_tp_watchdog.sv
// Timer watchdog: saturating counter that advances every other enabled
// cycle and flags expiry once it reaches LIMIT.
module agc_tp_watchdog #(
    parameter int LIMIT = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;
    logic          half;

    // Count every second enabled cycle, hold at LIMIT, restart on clear.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            half  <= 1'b0;
        end else if (clr) begin
            count <= '0;
            half  <= 1'b0;
        end else if (en) begin
            half <= ~half;
            if (half && count != CW'(LIMIT)) count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/agc_timepulse_decoder.sv
// AGC time-pulse decoder: rebuilds T01..T12 from the timer CT/EVNSET/P01..P05
// interface, counts memory cycles and latches a timer-fail alarm on watchdog,
// sync or Johnson-phase faults.
// Optional build macro AGC_TPDEC_STATS_EN adds saturating per-fault counters.
module agc_timepulse_decoder
    import agc_timing_pkg::*;
#(
    parameter int WDOG_LIMIT = 24,
    parameter int MCT_W      = 16
) (
    input  logic                SIM_CLK,
    input  logic                SIM_RST,
    input  logic                CT,
    input  logic                EVNSET,
    input  logic                P01,
    input  logic                P02,
    input  logic                P03,
    input  logic                P04,
    input  logic                P05,
    input  logic                CLR_FAIL,
    output logic [11:0]         TP_,
    output logic [3:0]          TPNUM,
    output logic                SYNCED,
    output logic                TMRFAIL,
    output logic [1:0]          FAIL_CODE,
    output logic [MCT_W-1:0]    MCTCNT
`ifdef AGC_TPDEC_STATS_EN
    ,
    output logic [7:0]          WDOG_ERRS,
    output logic [7:0]          SYNC_ERRS,
    output logic [7:0]          PHASE_ERRS
`endif
);

    tpdec_state_e state;
    logic         ct_q;
    logic [4:0]   p_q;
    logic [4:0]   p_vec;
    logic         ct_edge;
    logic         at_t12;
    logic [3:0]   tp_next;
    logic         phase_err;
    logic         sync_err;
    logic         wdog_err;
    logic         wdog_expired;
    logic [1:0]   fault_code;

    assign p_vec   = {P05, P04, P03, P02, P01};
    assign ct_edge = CT & ~ct_q;
    assign at_t12  = (TPNUM == 4'(TP_COUNT));
    assign tp_next = at_t12 ? 4'd1 : TPNUM + 4'd1;

    // A P change is legal only as one Johnson step; holding still is always legal.
    assign phase_err = (state == TPDEC_SYNC) && (p_vec != p_q) && (p_vec != johnson_next(p_q));
    // EVNSET must accompany exactly the T12 -> T01 edge.
    assign sync_err  = (state == TPDEC_SYNC) && ct_edge && (EVNSET != at_t12);
    // A CT edge arriving in the expiry cycle rescues the watchdog.
    assign wdog_err  = (state == TPDEC_SYNC) && wdog_expired && !ct_edge;

    agc_tp_watchdog #(
        .LIMIT (WDOG_LIMIT)
    ) u_watchdog (
        .clk     (SIM_CLK),
        .rst_n   (SIM_RST),
        .clr     (ct_edge | (state != TPDEC_SYNC)),
        .en      (state == TPDEC_SYNC),
        .expired (wdog_expired)
    );

    // Resolve simultaneous faults: phase beats sync beats watchdog.
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        fault_code = FC_NONE;
        if (phase_err)      fault_code = FC_PHASE;
        else if (sync_err)  fault_code = FC_SYNC;
        else if (wdog_err)  fault_code = FC_WDOG;
    end

    // Decoder FSM with registered pulse, status and memory-cycle outputs.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state     <= TPDEC_UNSYNC;
            ct_q      <= 1'b0;
            p_q       <= '0;
            TP_       <= '1;
            TPNUM     <= '0;
            SYNCED    <= 1'b0;
            TMRFAIL   <= 1'b0;
            FAIL_CODE <= FC_NONE;
            MCTCNT    <= '0;
        end else begin
            ct_q <= CT;
            p_q  <= p_vec;
            case (state)
                TPDEC_UNSYNC: begin
                    if (ct_edge && EVNSET) begin
                        state  <= TPDEC_SYNC;
                        TPNUM  <= 4'd1;
                        TP_    <= tp_decode(4'd1);
                        SYNCED <= 1'b1;
                    end
                end
                TPDEC_SYNC: begin
                    if (fault_code != FC_NONE) begin
                        state     <= TPDEC_FAIL;
                        TPNUM     <= '0;
                        TP_       <= '1;
                        SYNCED    <= 1'b0;
                        TMRFAIL   <= 1'b1;
                        FAIL_CODE <= fault_code;
                    end else if (ct_edge) begin
                        TPNUM <= tp_next;
                        TP_   <= tp_decode(tp_next);
                        if (at_t12) MCTCNT <= MCTCNT + 1'b1;
                    end
                end
                TPDEC_FAIL: begin
                    if (CLR_FAIL) begin
                        state     <= TPDEC_UNSYNC;
                        TMRFAIL   <= 1'b0;
                        FAIL_CODE <= FC_NONE;
                    end
                end
                default: begin
                    state <= TPDEC_UNSYNC;
                end
            endcase
        end
    end

`ifdef AGC_TPDEC_STATS_EN
    // Count each entry into FAIL by fault code, saturating at 255.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            WDOG_ERRS  <= '0;
            SYNC_ERRS  <= '0;
            PHASE_ERRS <= '0;
        end else if (state == TPDEC_SYNC) begin
            case (fault_code)
                FC_WDOG:  if (WDOG_ERRS  != 8'hFF) WDOG_ERRS  <= WDOG_ERRS  + 8'd1;
                FC_SYNC:  if (SYNC_ERRS  != 8'hFF) SYNC_ERRS  <= SYNC_ERRS  + 8'd1;
                FC_PHASE: if (PHASE_ERRS != 8'hFF) PHASE_ERRS <= PHASE_ERRS + 8'd1;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: doc/agc_timepulse_decoder.md
Name: agc_timepulse_decoder

Overview:
- Receiving end of the a2_timer timing interface.
- Consumes the timer's CT stage clock, EVNSET memory-cycle marker and P01..P05 Johnson stage outputs.
- Reconstructs the AGC time-pulse sequence T01..T12 as active-low one-hot lines, counts memory cycles (MCT), and supervises the timer: watchdog, sync check and Johnson-sequence check, latching a timer-fail alarm.

Parameters:
- WDOG_LIMIT, 24: SIM_CLK cycles without a CT rising edge, while synced, before a watchdog fault.
- MCT_W, 16: width of the memory-cycle counter.

Ports:
- SIM_CLK  input  1  sole clock; all logic on rising edge.
- SIM_RST  input  1  asynchronous, active-low reset.
- CT  input  1  timer stage clock; each rising edge advances one time pulse.
- EVNSET  input  1  high during T12; qualifies the T12->T01 wrap.
- P01, P02, P03, P04, P05  input  1 each  timer Johnson stage bits; vector {P05..P01}.
- CLR_FAIL  input  1  one-cycle pulse; leaves FAIL.
- TP_  output  12  active-low one-hot time pulses; bit0=T01 ... bit11=T12.
- TPNUM  output  4  current pulse number 1..12; 0 when not synced.
- SYNCED  output  1  high in SYNC state.
- TMRFAIL  output  1  latched timer-fail alarm.
- FAIL_CODE  output  2  01 watchdog, 10 sync, 11 phase; 00 when no fault.
- MCTCNT  output  MCT_W  completed memory cycles.

Behaviour:
- Reset (SIM_RST=0, async): TP_=12'hFFF, TPNUM=0, SYNCED=0, TMRFAIL=0, FAIL_CODE=0, MCTCNT=0, state UNSYNC, edge and P registers cleared.
- Edge detection: CT registered to ct_q; edge = CT & ~ct_q.
- Outputs are registered and update on the clock following the cycle in which edge is high (1-cycle latency from CT sampled high).
- UNSYNC:
  - TP_ all ones, TPNUM=0.
  - An edge with EVNSET=1 -> SYNC with TPNUM=1 (T01 low). Other edges are ignored.
  - Watchdog and checks are inactive.
- SYNC, on edge:
  - TPNUM 1..11 -> TPNUM+1.
  - TPNUM=12 with EVNSET=1 -> TPNUM=1, MCTCNT+1; MCTCNT wraps modulo 2^MCT_W.
- Sync fault: edge with EVNSET=1 while TPNUM!=12, or edge with EVNSET=0 while TPNUM=12 -> FAIL, code 10.
- Phase check (SYNC only):
  - P vector registered each cycle.
  - Any change must equal {prev[3:0], ~prev[4]}; otherwise -> FAIL, code 11.
  - No change is always legal.
- Watchdog:
  - Counter cleared on each edge and on entry to SYNC.
  - Increments every other SYNC cycle, saturating.
  - Reaching WDOG_LIMIT -> FAIL, code 01.
  - An edge in the same cycle as expiry wins: no fault.
- Simultaneous faults: priority phase > sync > watchdog. FAIL_CODE records the winner only.
- FAIL:
  - TP_ all ones, TPNUM=0, SYNCED=0, TMRFAIL=1, FAIL_CODE held.
  - MCTCNT held.
  - CLR_FAIL -> UNSYNC, TMRFAIL=0, FAIL_CODE=0.
  - CLR_FAIL outside FAIL is ignored.
- Exactly one TP_ bit is low in SYNC; none in other states.
- States are encoded UNSYNC=0, SYNC=1, FAIL=2.

Optional Feature:
- Macro: AGC_TPDEC_STATS_EN.
- Defined:
  - Adds outputs WDOG_ERRS, SYNC_ERRS, PHASE_ERRS (8 bits each, saturating at 255).
  - Each increments on entry to FAIL with the matching code.
  - Cleared only by SIM_RST.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package agc_timing_pkg holds:
  - state enum TPDEC_UNSYNC/SYNC/FAIL;
  - FAIL_CODE constants FC_NONE/FC_WDOG/FC_SYNC/FC_PHASE;
  - TP_COUNT=12;
  - function johnson_next(5-bit).
- One sub-module: agc_tp_watchdog (saturating counter, clear, enable, expiry at limit). The rest stays flat.

Test Plan:
- Reset, then CT edges with EVNSET=1 on the first edge and on every 12th edge afterward, Johnson P stepping legally, 36 edges total -> TP_ walks 12'hFFE..12'h7FF three times; MCTCNT=2 after the last wrap, =3 after the next wrap; TMRFAIL=0.
- CT edges while UNSYNC with EVNSET=0 -> TP_=12'hFFF, TPNUM=0; the first EVNSET-qualified edge -> TPNUM=1 exactly 1 cycle later.
- Synced at TPNUM=5, edge with EVNSET=1 -> TMRFAIL=1, FAIL_CODE=2'b10, TP_=12'hFFF; CLR_FAIL pulse -> UNSYNC, TMRFAIL=0.
- Synced, P goes 5'b00011 -> 5'b00101 in the same cycle as an EVNSET-less edge at TPNUM=12 -> FAIL_CODE=2'b11 (phase priority).
- Synced, CT held low 2*WDOG_LIMIT=48 cycles -> TMRFAIL=1, FAIL_CODE=2'b01; repeat with an edge landing in the expiry cycle -> no fault, TPNUM advances.
- Assert SIM_RST mid-cycle while synced at TPNUM=7, MCTCNT=9 -> all outputs return to reset values immediately, without a clock.
